// File: rtl/uart_arb_pkg.sv
// Shared definitions for the UART transmit arbiter: FSM state encoding and
// the default acknowledge-timeout constant.
package uart_arb_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE      = 2'd0,
        ARB_START     = 2'd1,
        ARB_WAIT_ACK  = 2'd2,
        ARB_WAIT_DONE = 2'd3
    } arb_state_t;

    // Cycles to wait in WAIT_ACK for the transmitter to report busy.
    localparam int ACK_TIMEOUT_DEF = 15;

    // Width of the acknowledge-timeout counter.
    localparam int ACK_CNT_W = 4;

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Requester / transmitter bus of the UART transmit arbiter.
// master: requesters plus the UART transmitter (the environment).
// slave : the arbiter itself.
interface uart_tx_arbiter_if #(
    parameter int NREQ = 2
);
    logic [NREQ-1:0]   req_valid_i;
    logic [8*NREQ-1:0] req_data_i;
    logic [NREQ-1:0]   req_ready_o;
    logic              tx_start_o;
    logic [7:0]        tx_data_o;
    logic              tx_busy_i;
    logic [NREQ-1:0]   grant_o;
    logic              err_o;

    modport master (
        output req_valid_i, req_data_i, tx_busy_i,
        input  req_ready_o, tx_start_o, tx_data_o, grant_o, err_o
    );

    modport slave (
        input  req_valid_i, req_data_i, tx_busy_i,
        output req_ready_o, tx_start_o, tx_data_o, grant_o, err_o
    );
endinterface

// File: rtl/uart_arb_pick.sv
// Winner selection: first valid requester found when scanning upward from
// ptr with wrap-around. With ptr held at zero this is fixed lowest-index
// priority.
module uart_arb_pick #(
    parameter int NREQ  = 2,
    parameter int PTR_W = 1
) (
    input  logic [NREQ-1:0]  valid,
    input  logic [PTR_W-1:0] ptr,
    output logic [NREQ-1:0]  gnt
);

    logic [PTR_W-1:0] idx;
    logic             found;

    // Rotating scan starting at ptr; only the first hit is granted.
    always_comb begin
        gnt   = '0;
        found = 1'b0;
        idx   = '0;
        for (int i = 0; i < NREQ; i++) begin
            idx = PTR_W'((int'(ptr) + i) % NREQ);
            if (!found && valid[idx]) begin
                gnt[idx] = 1'b1;
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// UART transmit arbiter: shares one UART transmitter among NREQ byte
// requesters. Accepts a byte in IDLE, pulses tx_start_o, waits for the
// transmitter to go busy (with timeout) and then to go idle again.
// Build option: define UART_ARB_ROUND_ROBIN_EN for round-robin arbitration;
// otherwise fixed priority, lowest index wins.
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter int NREQ        = 2,
    parameter int ACK_TIMEOUT = ACK_TIMEOUT_DEF
) (
    input  logic              clk,
    input  logic              rst_b,
    uart_tx_arbiter_if.slave  bus
);

    localparam int PTR_W = (NREQ > 2) ? 2 : 1;

    arb_state_t             state, state_nxt;
    logic [ACK_CNT_W-1:0]   ack_cnt;
    logic [PTR_W-1:0]       ptr;
    logic [NREQ-1:0]        pick;
    logic [7:0]             win_byte;
    logic [PTR_W-1:0]       win_idx;
    logic                   accept;
    logic                   timeout;
    logic [7:0]             data_q;
    logic [NREQ-1:0]        grant_q;

    uart_arb_pick #(.NREQ(NREQ), .PTR_W(PTR_W)) u_pick (
        .valid (bus.req_valid_i),
        .ptr   (ptr),
        .gnt   (pick)
    );

    // A foreign or stale transmission (busy high) blocks acceptance in IDLE.
    assign accept  = (state == ARB_IDLE) && (|bus.req_valid_i) && !bus.tx_busy_i;
    assign timeout = (state == ARB_WAIT_ACK) && !bus.tx_busy_i &&
                     (ack_cnt == ACK_CNT_W'(ACK_TIMEOUT));

    // Extract the winning byte and its index from the one-hot pick.
    always_comb begin
        win_byte = 8'h00;
        win_idx  = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (pick[k]) begin
                win_byte = bus.req_data_i[8*k +: 8];
                win_idx  = PTR_W'(k);
            end
        end
    end

`ifdef UART_ARB_ROUND_ROBIN_EN
    // Round-robin pointer: next search starts just after the last winner.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b)
            ptr <= '0;
        else if (accept)
            ptr <= (win_idx == PTR_W'(NREQ - 1)) ? '0 : win_idx + 1'b1;
    end
`else
    assign ptr = '0;
`endif

    // State register.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b)
            state <= ARB_IDLE;
        else
            state <= state_nxt;
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            ARB_IDLE:      if (accept)          state_nxt = ARB_START;
            ARB_START:                          state_nxt = ARB_WAIT_ACK;
            ARB_WAIT_ACK:  if (bus.tx_busy_i)   state_nxt = ARB_WAIT_DONE;
                           else if (timeout)    state_nxt = ARB_IDLE;
            ARB_WAIT_DONE: if (!bus.tx_busy_i)  state_nxt = ARB_IDLE;
            default:                            state_nxt = ARB_IDLE;
        endcase
    end

    // Acknowledge counter: zero outside WAIT_ACK, so it is clear on entry.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b)
            ack_cnt <= '0;
        else if (state == ARB_WAIT_ACK && state_nxt == ARB_WAIT_ACK)
            ack_cnt <= ack_cnt + 1'b1;
        else
            ack_cnt <= '0;
    end

    // Latch the accepted byte and owner; owner drops on return to IDLE.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            data_q  <= 8'h00;
            grant_q <= '0;
        end else if (accept) begin
            data_q  <= win_byte;
            grant_q <= pick;
        end else if (state != ARB_IDLE && state_nxt == ARB_IDLE) begin
            grant_q <= '0;
        end
    end

    // Output decode.
    always_comb begin
        bus.req_ready_o = accept ? pick : '0;
        bus.tx_start_o  = (state == ARB_START);
        bus.err_o       = timeout;
        bus.tx_data_o   = data_q;
        bus.grant_o     = grant_q;
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed self-checking bench for uart_tx_arbiter (NREQ=2, ACK_TIMEOUT=15).
// Expected round-robin vs fixed-priority ordering follows
// UART_ARB_ROUND_ROBIN_EN.
module tb_uart_tx_arbiter;

    localparam int NREQ = 2;
    localparam int ATO  = 15;

    logic clk;
    logic rst_b;
    int   checks;
    int   failures;

    uart_tx_arbiter_if #(.NREQ(NREQ)) bus ();

    uart_tx_arbiter #(.NREQ(NREQ), .ACK_TIMEOUT(ATO)) dut (
        .clk   (clk),
        .rst_b (rst_b),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Global time limit so the run always ends.
    initial begin
        #300000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Serve one transfer: wait (bounded) for tx_start_o, capture the byte,
    // then act as a UART that is busy for three cycles.
    task automatic serve(output logic [7:0] b, output bit seen);
        seen = 1'b0;
        b    = 8'h00;
        for (int i = 0; i < 10 && !seen; i++) begin
            if (bus.tx_start_o) begin
                seen = 1'b1;
                b    = bus.tx_data_o;
            end else begin
                tick();
            end
        end
        if (seen) begin
            tick();
            bus.tx_busy_i = 1'b1;
            tick(); tick(); tick();
            bus.tx_busy_i = 1'b0;
            tick();
        end
    endtask

    initial begin
        int         bad;
        int         first_k;
        int         npulse;
        logic [7:0] b;
        bit         seen;
        logic [7:0] exp_seq [4];

        checks   = 0;
        failures = 0;
        rst_b    = 1'b0;
        bus.req_valid_i = '0;
        bus.req_data_i  = '0;
        bus.tx_busy_i   = 1'b0;
        #2;

        // Reset state
        chk("rst_ready", 32'(bus.req_ready_o), 32'h0);
        chk("rst_start", 32'(bus.tx_start_o),  32'h0);
        chk("rst_data",  32'(bus.tx_data_o),   32'h0);
        chk("rst_grant", 32'(bus.grant_o),     32'h0);
        chk("rst_err",   32'(bus.err_o),       32'h0);
        tick(); tick();
        rst_b = 1'b1;
        tick();

        // Single request from req0, UART busy 2 cycles after start for 320 cycles
        bus.req_valid_i = 2'b01;
        bus.req_data_i  = 16'h00A5;
        #1;
        chk("single_ready", 32'(bus.req_ready_o), 32'h1);
        tick();
        chk("single_start", 32'(bus.tx_start_o), 32'h1);
        chk("single_data",  32'(bus.tx_data_o),  32'hA5);
        chk("single_grant", 32'(bus.grant_o),    32'h1);
        bus.req_valid_i = 2'b00;
        tick();
        chk("single_start_once", 32'(bus.tx_start_o), 32'h0);
        tick();
        bus.tx_busy_i = 1'b1;
        bad = 0;
        for (int i = 0; i < 320; i++) begin
            tick();
            if (bus.grant_o !== 2'b01 || bus.err_o !== 1'b0 || bus.tx_start_o !== 1'b0 ||
                bus.tx_data_o !== 8'hA5 || bus.req_ready_o !== 2'b00)
                bad++;
        end
        chk("single_hold_cycles_bad", 32'(bad), 32'h0);
        bus.tx_busy_i = 1'b0;
        tick();
        chk("single_idle_grant", 32'(bus.grant_o), 32'h0);

        // Acknowledge timeout: UART never goes busy
        bus.req_valid_i = 2'b01;
        bus.req_data_i  = 16'h003C;
        #1;
        chk("to_ready", 32'(bus.req_ready_o), 32'h1);
        tick();
        chk("to_start", 32'(bus.tx_start_o), 32'h1);
        bus.req_valid_i = 2'b00;
        first_k = -1;
        npulse  = 0;
        for (int k = 1; k <= 30; k++) begin
            tick();
            if (bus.err_o === 1'b1) begin
                npulse++;
                if (first_k < 0) first_k = k;
            end
        end
        chk("to_err_delay",  32'(first_k), 32'(ATO + 1));
        chk("to_err_pulses", 32'(npulse),  32'h1);
        chk("to_idle_grant", 32'(bus.grant_o), 32'h0);
        bus.req_valid_i = 2'b01;
        bus.req_data_i  = 16'h0042;
        #1;
        chk("to_next_ready", 32'(bus.req_ready_o), 32'h1);
        tick();
        chk("to_next_data", 32'(bus.tx_data_o), 32'h42);
        bus.req_valid_i = 2'b00;
        tick();
        bus.tx_busy_i = 1'b1;
        tick();
        bus.tx_busy_i = 1'b0;
        tick();

        // Busy at idle: no accept while busy, accept as soon as it falls
        bus.tx_busy_i   = 1'b1;
        bus.req_valid_i = 2'b01;
        bus.req_data_i  = 16'h0077;
        bad = 0;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (bus.req_ready_o !== 2'b00 || bus.tx_start_o !== 1'b0) bad++;
        end
        chk("busyidle_ready_cycles", 32'(bad), 32'h0);
        bus.tx_busy_i = 1'b0;
        #1;
        chk("busyidle_accept", 32'(bus.req_ready_o), 32'h1);
        tick();
        chk("busyidle_start", 32'(bus.tx_start_o), 32'h1);
        chk("busyidle_data",  32'(bus.tx_data_o),  32'h77);
        bus.req_valid_i = 2'b00;
        tick();
        bus.tx_busy_i = 1'b1;
        tick();
        chk("busyidle_grant_wd", 32'(bus.grant_o), 32'h1);

        // Reset during WAIT_DONE
        rst_b = 1'b0;
        #1;
        chk("midrst_grant", 32'(bus.grant_o),   32'h0);
        chk("midrst_data",  32'(bus.tx_data_o), 32'h0);
        chk("midrst_start", 32'(bus.tx_start_o), 32'h0);
        chk("midrst_err",   32'(bus.err_o),     32'h0);
        bus.req_valid_i = 2'b01;
        bus.req_data_i  = 16'h0099;
        tick();
        rst_b = 1'b1;
        tick();
        chk("midrst_ready_busy", 32'(bus.req_ready_o), 32'h0);
        chk("midrst_err_after",  32'(bus.err_o),       32'h0);
        bus.tx_busy_i = 1'b0;
        #1;
        chk("midrst_accept", 32'(bus.req_ready_o), 32'h1);
        tick();
        chk("midrst_data2", 32'(bus.tx_data_o), 32'h99);
        bus.req_valid_i = 2'b00;
        tick();
        bus.tx_busy_i = 1'b1;
        tick();
        bus.tx_busy_i = 1'b0;
        tick();

        // Back-to-back from req1: 0x5A then 0xC3
        bus.req_valid_i = 2'b10;
        bus.req_data_i  = 16'h5A00;
        #1;
        chk("b2b_ready1", 32'(bus.req_ready_o), 32'h2);
        tick();
        chk("b2b_start1", 32'(bus.tx_start_o), 32'h1);
        chk("b2b_grant1", 32'(bus.grant_o),    32'h2);
        chk("b2b_data1",  32'(bus.tx_data_o),  32'h5A);
        bus.req_data_i = 16'hC300;
        tick();
        bus.tx_busy_i = 1'b1;
        tick(); tick();
        chk("b2b_ready_wd", 32'(bus.req_ready_o), 32'h0);
        bus.tx_busy_i = 1'b0;
        tick();
        chk("b2b_gap_grant", 32'(bus.grant_o),    32'h0);
        chk("b2b_gap_start", 32'(bus.tx_start_o), 32'h0);
        chk("b2b_ready2",    32'(bus.req_ready_o), 32'h2);
        tick();
        chk("b2b_start2", 32'(bus.tx_start_o), 32'h1);
        chk("b2b_data2",  32'(bus.tx_data_o),  32'hC3);
        bus.req_valid_i = 2'b00;
        tick();
        bus.tx_busy_i = 1'b1;
        tick();
        bus.tx_busy_i = 1'b0;
        tick();

        // Both requesters held valid continuously
`ifdef UART_ARB_ROUND_ROBIN_EN
        exp_seq = '{8'h11, 8'h22, 8'h11, 8'h22};
`else
        exp_seq = '{8'h11, 8'h11, 8'h11, 8'h11};
`endif
        bus.req_valid_i = 2'b11;
        bus.req_data_i  = 16'h2211;
        for (int n = 0; n < 4; n++) begin
            serve(b, seen);
            chk($sformatf("arb_seen%0d", n), 32'(seen), 32'h1);
            chk($sformatf("arb_byte%0d", n), 32'(b),    32'(exp_seq[n]));
        end
        bus.req_valid_i = 2'b00;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter NREQ, default 2: number of byte requesters sharing the single UART transmitter, range 2..4.
REQ-002 Parameter ACK_TIMEOUT, default 15: max cycles to wait for tx_busy_i to rise after tx_start_o.
REQ-003 clk  input  1  system clock; single clock domain.
REQ-004 rst_b  input  1  asynchronous, active-low reset.
REQ-005 req_valid_i  input  NREQ  per-requester byte-valid.
REQ-006 req_data_i  input  8*NREQ  per-requester byte; requester k uses bits [8k+7:8k].
REQ-007 req_ready_o  output  NREQ  one-hot accept strobe, at most one bit high per cycle.
REQ-008 tx_start_o  output  1  one-cycle start pulse to the UART transmitter.
REQ-009 tx_data_o  output  8  byte presented to the UART transmitter, stable from tx_start_o until return to IDLE.
REQ-010 tx_busy_i  input  1  UART transmitter busy, high from start bit through stop bit.
REQ-011 grant_o  output  NREQ  one-hot owner of the transmitter; zero in IDLE.
REQ-012 err_o  output  1  one-cycle pulse on acknowledge timeout.

Function
REQ-013 FSM states: IDLE, START, WAIT_ACK, WAIT_DONE; encoding 2 bits.
REQ-014 IDLE: when any req_valid_i bit is set and tx_busy_i==0, pick winner, assert its req_ready_o bit in the same cycle (combinational), latch its byte into tx_data_o and its index into grant_o at the clock edge, go to START.
REQ-015 IDLE with tx_busy_i==1 (foreign or stale transmission): no req_ready_o, remain IDLE.
REQ-016 Handshake: a byte is transferred only on a cycle with req_valid_i[k] && req_ready_o[k]; requesters hold valid and data stable until accepted.
REQ-017 START: tx_start_o=1 for exactly this one cycle, then go to WAIT_ACK; latency from accept edge to tx_start_o high is 1 cycle.
REQ-018 WAIT_ACK: on tx_busy_i==1 go to WAIT_DONE; a 4-bit cycle counter, cleared on entry, increments each cycle; when it reaches ACK_TIMEOUT with tx_busy_i still 0, pulse err_o, go to IDLE.
REQ-019 WAIT_DONE: on tx_busy_i==0 go to IDLE; no timeout in this state.
REQ-020 grant_o clears on the transition into IDLE; a new accept is possible on the first IDLE cycle (back-to-back bytes separated by exactly one IDLE cycle).
REQ-021 req_ready_o is 0 in all states except IDLE.
REQ-022 Requester valid deasserted after acceptance has no effect on the transfer in progress.

Reset
REQ-023 rst_b low asynchronously forces state IDLE, req_ready_o=0, tx_start_o=0, tx_data_o=8'h00, grant_o=0, err_o=0, timeout counter=0, round-robin pointer=0.
REQ-024 Reset mid-transfer abandons the byte without err_o; on release the block is in IDLE and ignores tx_busy_i until it falls.

Configuration
REQ-025 Macro UART_ARB_ROUND_ROBIN_EN defined: winner is the first valid requester at or after (last_grant+1) mod NREQ; pointer updates on each accept.
REQ-026 Macro undefined: fixed priority, lowest index wins; no pointer register is synthesised.

Structure
REQ-027 Shared package uart_arb_pkg holds the FSM state constants (ARB_IDLE, ARB_START, ARB_WAIT_ACK, ARB_WAIT_DONE) and the default ACK_TIMEOUT constant.
REQ-028 Winner selection resides in sub-module uart_arb_pick (inputs valid vector and pointer, output one-hot grant); the FSM stays in the top module.

Verification
REQ-029 Single request: req 0 sends 0xA5, UART model raises busy 2 cycles after start for 320 cycles -> one tx_start_o pulse, tx_data_o=0xA5, grant_o=01 through WAIT_DONE, err_o never pulses.
REQ-030 Simultaneous requests, round-robin build: req0=0x11, req1=0x22 held valid continuously -> tx order 0x11, 0x22, 0x11, 0x22; fixed-priority build -> 0x11 repeated, req1 starved.
REQ-031 Timeout: UART model never raises busy -> err_o pulses exactly once, ACK_TIMEOUT+1 cycles after tx_start_o, FSM back in IDLE, next request accepted.
REQ-032 Busy at idle: tx_busy_i held high 50 cycles with req0 valid -> req_ready_o stays 0 until busy falls, then accepts within 1 cycle.
REQ-033 Reset mid-transfer: assert rst_b low during WAIT_DONE -> all outputs zero immediately, no err_o, clean accept after busy falls.
REQ-034 Back-to-back: req1 sends 0x5A then 0xC3 -> two tx_start_o pulses, second exactly 2 cycles after busy falls from the first.
